// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 register file (Count, Compare, Status, Cause,
// EPC, BadVAddr, PRId, Config) with Count prescaler, sticky timer interrupt,
// masked interrupt detection and exception/eret sequencing.
// Optional build macro: CP0_FORWARD_EN -- when defined, an mfc0 that reads the
// register being written by mtc0 in the same cycle sees the post-write value.
// No handshakes: every input is a single-cycle qualifier sampled at the rising
// clock edge; rdata is a purely combinational view of the register file.
module cp0_unit #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic                  exc_badv_we,
    input  logic [31:0]           exc_badv,
    input  logic                  eret,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_pending,
    output logic [31:0]           exc_vector,
    output logic                  timer_int
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;
    localparam logic [4:0]  REG_CONFIG   = 5'd16;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
    localparam logic [3:0]  PRESC_MAX    = 4'(COUNT_DIV - 1);

    // Architectural state
    logic [31:0] count_q, compare_q, status_q, epc_q, badv_q;
    logic [3:0]  presc_q;
    logic        timer_q, bd_q, int_pend_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  sw_ip_q;
    logic [5:0]  hw_ip_q;

    // Next-state values
    logic [31:0] count_n, compare_n, status_n, epc_n, badv_n;
    logic [3:0]  presc_n;
    logic        timer_n, bd_n, int_pend_n;
    logic [4:0]  exc_code_n;
    logic [1:0]  sw_ip_n;
    logic [5:0]  hw_ext;
    logic [7:0]  ip_n;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [7:0]  ip_cur;
    logic [31:0] cause_val;
    logic [31:0] reg_val;

    assign wr_count   = we && (waddr == REG_COUNT);
    assign wr_compare = we && (waddr == REG_COMPARE);
    assign wr_status  = we && (waddr == REG_STATUS);
    assign wr_cause   = we && (waddr == REG_CAUSE);
    assign wr_epc     = we && (waddr == REG_EPC);

    // Zero-extend the hardware interrupt lines to the full six IP slots
    always_comb begin
        hw_ext                 = '0;
        hw_ext[NUM_HW_INT-1:0] = hw_int;
    end

    // Assemble the Cause view; the timer shares IP7 with the top hw line
    always_comb begin
        ip_cur    = {hw_ip_q[5] | timer_q, hw_ip_q[4:0], sw_ip_q};
        cause_val = {bd_q, timer_q, 14'b0, ip_cur, 1'b0, exc_code_q, 2'b00};
    end

    // Next-state logic: exception beats eret beats mtc0 on shared fields
    always_comb begin
        // Count and its prescaler; an mtc0 Count restarts the prescale period
        count_n = count_q;
        presc_n = presc_q + 4'd1;
        if (presc_q == PRESC_MAX) begin
            count_n = count_q + 32'd1;
            presc_n = 4'd0;
        end
        if (wr_count) begin
            count_n = wdata;
            presc_n = 4'd0;
        end

        compare_n = wr_compare ? wdata : compare_q;

        // Sticky timer flag; rewriting Compare acknowledges it
        timer_n = timer_q | ((count_q == compare_q) && (compare_q != 32'd0));
        if (wr_compare) begin
            timer_n = 1'b0;
        end

        // Status: mtc0 writes everything, EXL is then overridden by events
        status_n = wr_status ? wdata : status_q;
        if (exc_valid) begin
            status_n[1] = 1'b1;
        end else if (eret) begin
            status_n[1] = 1'b0;
        end

        // EPC/BD only latch on the first exception (EXL clear)
        epc_n      = wr_epc ? wdata : epc_q;
        bd_n       = bd_q;
        exc_code_n = exc_code_q;
        badv_n     = badv_q;
        if (exc_valid) begin
            exc_code_n = exc_code;
            if (!status_q[1]) begin
                epc_n = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_n  = exc_bd;
            end
            if (exc_badv_we) begin
                badv_n = exc_badv;
            end
        end

        sw_ip_n = wr_cause ? wdata[9:8] : sw_ip_q;

        // Pending interrupt uses next-cycle IP and Status so it is aligned
        ip_n       = {hw_ext[5] | timer_n, hw_ext[4:0], sw_ip_n};
        int_pend_n = status_n[0] & ~status_n[1] & (|(ip_n & status_n[15:8]));
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badv_q     <= '0;
            presc_q    <= '0;
            timer_q    <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            sw_ip_q    <= '0;
            hw_ip_q    <= '0;
            int_pend_q <= 1'b0;
        end else begin
            count_q    <= count_n;
            compare_q  <= compare_n;
            status_q   <= status_n;
            epc_q      <= epc_n;
            badv_q     <= badv_n;
            presc_q    <= presc_n;
            timer_q    <= timer_n;
            bd_q       <= bd_n;
            exc_code_q <= exc_code_n;
            sw_ip_q    <= sw_ip_n;
            hw_ip_q    <= hw_ext;
            int_pend_q <= int_pend_n;
        end
    end

    // mfc0 read mux over the registered state
    always_comb begin
        case (raddr)
            REG_BADVADDR: reg_val = badv_q;
            REG_COUNT:    reg_val = count_q;
            REG_COMPARE:  reg_val = compare_q;
            REG_STATUS:   reg_val = status_q;
            REG_CAUSE:    reg_val = cause_val;
            REG_EPC:      reg_val = epc_q;
            REG_PRID:     reg_val = PRID_VALUE;
            REG_CONFIG:   reg_val = CONFIG_VALUE;
            default:      reg_val = 32'd0;
        endcase
    end

`ifdef CP0_FORWARD_EN
    // Bypass a same-cycle mtc0 to the register being read
    always_comb begin
        rdata = reg_val;
        if (we && (raddr == waddr)) begin
            case (waddr)
                REG_COUNT:   rdata = wdata;
                REG_COMPARE: rdata = wdata;
                REG_STATUS:  rdata = wdata;
                REG_EPC:     rdata = wdata;
                REG_CAUSE:   rdata = (cause_val & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
                default:     rdata = reg_val;
            endcase
        end
    end
`else
    // Reads always reflect the registered value; writes show up next cycle
    always_comb begin
        rdata = reg_val;
    end
`endif

    assign status_o    = status_q;
    assign cause_o     = cause_val;
    assign epc_o       = epc_q;
    assign int_pending = int_pend_q;
    assign timer_int   = timer_q;
    assign exc_vector  = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit (default parameters).
// Expected values are queued before each stimulus step and popped when the
// corresponding DUT output is sampled, 1 ns after the rising edge.
module tb_cp0_unit;

    localparam int          NUM_HW_INT   = 6;
    localparam int          COUNT_DIV    = 2;
    localparam logic [31:0] PRID_VALUE   = 32'h004C0102;
    localparam logic [31:0] CONFIG_VALUE = 32'h00008000;
    localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  we;
    logic [4:0]            waddr;
    logic [31:0]           wdata;
    logic [4:0]            raddr;
    logic [31:0]           rdata;
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  exc_valid;
    logic [4:0]            exc_code;
    logic [31:0]           exc_pc;
    logic                  exc_bd;
    logic                  exc_badv_we;
    logic [31:0]           exc_badv;
    logic                  eret;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic [31:0]           epc_o;
    logic                  int_pending;
    logic [31:0]           exc_vector;
    logic                  timer_int;

    // Scoreboard
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] rd_val;

    cp0_unit #(
        .NUM_HW_INT  (NUM_HW_INT),
        .COUNT_DIV   (COUNT_DIV),
        .PRID_VALUE  (PRID_VALUE),
        .CONFIG_VALUE(CONFIG_VALUE),
        .EXC_VECTOR  (EXC_VECTOR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .hw_int     (hw_int),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .exc_pc     (exc_pc),
        .exc_bd     (exc_bd),
        .exc_badv_we(exc_badv_we),
        .exc_badv   (exc_badv),
        .eret       (eret),
        .status_o   (status_o),
        .cause_o    (cause_o),
        .epc_o      (epc_o),
        .int_pending(int_pending),
        .exc_vector (exc_vector),
        .timer_int  (timer_int)
    );

    // Clock
    always #5 clk = ~clk;

    // Queue one expectation
    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    // Pop the oldest expectation and compare against the observed value
    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] exp;
        string       tag;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=%h exp=<none>", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s got=%h exp=%h", tag, obs, exp);
            end
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we          = 1'b0;
        exc_valid   = 1'b0;
        exc_bd      = 1'b0;
        exc_badv_we = 1'b0;
        eret        = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        raddr = a;
        #1;
        d = rdata;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                             input logic bd, input logic bw, input logic [31:0] bv);
        exc_valid   = 1'b1;
        exc_code    = code;
        exc_pc      = pc;
        exc_bd      = bd;
        exc_badv_we = bw;
        exc_badv    = bv;
    endtask

    initial begin
        // Reset and defaults
        rst = 1'b0;
        idle_inputs();
        waddr = '0; wdata = '0; raddr = '0; hw_int = '0;
        exc_code = '0; exc_pc = '0; exc_badv = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // Asynchronous reset mid-run with Count = 0x55
        mtc0(5'd9, 32'h55);
        push("count_preload", 32'h55);
        rd(5'd9, rd_val); pop_check(rd_val);
        rst = 1'b0;
        #1;
        push("rst_status", 32'h10000000); pop_check(status_o);
        push("rst_cause", 32'h0);         pop_check(cause_o);
        push("rst_epc", 32'h0);           pop_check(epc_o);
        push("rst_int_pending", 32'h0);   pop_check({31'b0, int_pending});
        push("rst_timer_int", 32'h0);     pop_check({31'b0, timer_int});
        push("rst_count", 32'h0);
        rd(5'd9, rd_val); pop_check(rd_val);
        rst = 1'b1;
        push("count_after_release", 32'h0);
        rd(5'd9, rd_val); pop_check(rd_val);
        repeat (2 * COUNT_DIV) step();
        push("count_2div", 32'h2);
        rd(5'd9, rd_val); pop_check(rd_val);

        // Timer: Compare=5, Count=0
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (5 * COUNT_DIV) step();
        push("count_at_5", 32'd5);
        rd(5'd9, rd_val); pop_check(rd_val);
        push("timer_not_yet", 32'h0); pop_check({31'b0, timer_int});
        step();
        push("timer_set", 32'h1);     pop_check({31'b0, timer_int});
        push("cause_ti", 32'h1);      pop_check({31'b0, cause_o[30]});
        repeat (3) step();
        push("timer_sticky", 32'h1);  pop_check({31'b0, timer_int});
        mtc0(5'd11, 32'd5);
        push("timer_cleared", 32'h0); pop_check({31'b0, timer_int});

        // Count wrap
        mtc0(5'd9, 32'hFFFFFFFF);
        push("count_ffff", 32'hFFFFFFFF);
        rd(5'd9, rd_val); pop_check(rd_val);
        repeat (COUNT_DIV) step();
        push("count_wrap", 32'h0);
        rd(5'd9, rd_val); pop_check(rd_val);

        // Interrupt mask: disable timer, enable IE + all IM, raise hw_int[0]
        mtc0(5'd11, 32'd0);
        hw_int = 6'b000001;
        push("int_pending_on", 32'h1);
        push("cause_ip", 32'h04);
        mtc0(5'd12, 32'h0000FF01);
        pop_check({31'b0, int_pending});
        pop_check({24'b0, cause_o[15:8]});
        push("int_pending_im2_off", 32'h0);
        mtc0(5'd12, 32'h0000FB01);
        pop_check({31'b0, int_pending});
        push("int_pending_again", 32'h1);
        mtc0(5'd12, 32'h0000FF01);
        pop_check({31'b0, int_pending});
        push("int_pending_exl", 32'h0);
        push("status_exl_set", 32'h1);
        raise_exc(5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
        step();
        idle_inputs();
        pop_check({31'b0, int_pending});
        pop_check({31'b0, status_o[1]});
        push("eret_exl_clear", 32'h0);
        eret = 1'b1;
        step();
        idle_inputs();
        pop_check({31'b0, status_o[1]});

        // Delay-slot exception with BadVAddr
        push("ds_epc", 32'hBFC00100);
        push("ds_cause_bd", 32'h1);
        push("ds_exccode", 32'd4);
        push("ds_exl", 32'h1);
        push("ds_badv", 32'h1003);
        raise_exc(5'd4, 32'hBFC00104, 1'b1, 1'b1, 32'h1003);
        step();
        idle_inputs();
        pop_check(epc_o);
        pop_check({31'b0, cause_o[31]});
        pop_check({27'b0, cause_o[6:2]});
        pop_check({31'b0, status_o[1]});
        rd(5'd8, rd_val); pop_check(rd_val);

        // Nested exception while EXL=1
        push("nest_epc", 32'hBFC00100);
        push("nest_exccode", 32'd5);
        push("nest_bd_kept", 32'h1);
        raise_exc(5'd5, 32'h200, 1'b0, 1'b0, 32'h0);
        step();
        idle_inputs();
        pop_check(epc_o);
        pop_check({27'b0, cause_o[6:2]});
        pop_check({31'b0, cause_o[31]});

        // Exception collides with mtc0 EPC
        eret = 1'b1;
        step();
        idle_inputs();
        push("exc_beats_mtc0_epc", 32'h300);
        raise_exc(5'd6, 32'h300, 1'b0, 1'b0, 32'h0);
        we = 1'b1; waddr = 5'd14; wdata = 32'h1234;
        step();
        idle_inputs();
        pop_check(epc_o);

        // eret collides with mtc0 Status=3
        push("eret_beats_mtc0_exl", 32'h1);
        eret = 1'b1;
        mtc0(5'd12, 32'h3);
        idle_inputs();
        pop_check(status_o);

        // Same-cycle mfc0 of a register being written
        mtc0(5'd12, 32'h10000000);
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000FF01;
`ifdef CP0_FORWARD_EN
        push("fwd_rdata", 32'h0000FF01);
`else
        push("fwd_rdata", 32'h10000000);
`endif
        rd(5'd12, rd_val); pop_check(rd_val);
        push("status_after_write", 32'h0000FF01);
        step();
        idle_inputs();
        pop_check(status_o);

        // Read-only and unmapped registers, Cause write mask
        push("prid", PRID_VALUE);
        rd(5'd15, rd_val); pop_check(rd_val);
        push("config", CONFIG_VALUE);
        rd(5'd16, rd_val); pop_check(rd_val);
        push("unmapped", 32'h0);
        rd(5'd5, rd_val); pop_check(rd_val);
        push("exc_vector", EXC_VECTOR);
        pop_check(exc_vector);
        push("cause_sw_ip", 32'h3);
        push("cause_exccode_kept", 32'd6);
        mtc0(5'd13, 32'hFFFFFFFF);
        pop_check({30'b0, cause_o[9:8]});
        pop_check({27'b0, cause_o[6:2]});
        push("badv_readonly", 32'h1003);
        mtc0(5'd8, 32'hDEAD);
        rd(5'd8, rd_val); pop_check(rd_val);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Parametrised coprocessor-0 register unit for the MIPS core.
- Holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config.
- Adds the following:
  - a configurable Count prescaler
  - a configurable hardware-interrupt width
  - masked interrupt detection (int_pending)
  - exception-entry vector generation
  - defined priority when events collide
- Sits beside the exception/writeback stage, which drives exception events and mtc0/mfc0 accesses.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines. Range 1..6. They map to Cause.IP[2+NUM_HW_INT-1:2]; unused IP bits read 0.
- COUNT_DIV, 2, number of clk cycles per Count increment. Range 1..16.
- PRID_VALUE, 32'h004C0102, read-only PRId contents.
- CONFIG_VALUE, 32'h00008000, read-only Config contents.
- EXC_VECTOR, 32'hBFC00380, general exception entry address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- we  in  1  mtc0 write enable.
- waddr  in  5  mtc0 register number.
- wdata  in  32  mtc0 data.
- raddr  in  5  mfc0 register number.
- rdata  out  32  mfc0 data, combinational.
- hw_int  in  NUM_HW_INT  level hardware interrupts, already synchronised.
- exc_valid  in  1  exception commits this cycle.
- exc_code  in  5  ExcCode to record.
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a delay slot.
- exc_badv_we  in  1  load BadVAddr with exc_badv on this exception.
- exc_badv  in  32  faulting address.
- eret  in  1  eret commits this cycle.
- status_o  out  32  Status register.
- cause_o  out  32  Cause register.
- epc_o  out  32  EPC register.
- int_pending  out  1  enabled interrupt awaiting service.
- exc_vector  out  32  constant EXC_VECTOR.
- timer_int  out  1  timer interrupt flag (Cause.TI).

Behaviour:

Reset (rst=0, asynchronous):
- Count=0, Compare=0, EPC=0, BadVAddr=0, Cause=0.
- Status=32'h10000000.
- Prescaler=0, timer_int=0, int_pending=0.

Register numbers and writability:
- BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
- Other numbers read 0 and ignore writes.

Count prescaler:
- Counter runs 0..COUNT_DIV-1.
- Count increments (mod 2^32, wraps FFFFFFFF->0) in the cycle the prescaler equals COUNT_DIV-1; the prescaler then returns to 0.
- mtc0 Count: loads wdata and clears the prescaler. The write wins over an increment in the same cycle.

Timer:
- timer_int sets on the cycle after Count==Compare with Compare!=0.
- It is sticky; only an mtc0 Compare clears it. If set and clear coincide, the clear wins.
- Cause.TI (bit 30) = timer_int.
- Cause.IP7 = timer_int OR (NUM_HW_INT==6 ? hw_int[5] : 0).

Cause fields:
- IP[7:2] is sampled from hw_int every cycle.
- Only IP[1:0] (bits 9:8) are mtc0-writable.
- Status is fully writable except bit 1 (EXL) and bits 28 and 0, which are writable too. Status is a plain 32-bit store.

int_pending:
- Registered.
- Next value = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), using next-cycle Cause.IP and Status.IM.

Exception (exc_valid=1):
- EPC = exc_bd ? exc_pc-4 : exc_pc.
- Cause.BD = exc_bd.
- Cause.ExcCode = exc_code.
- Status.EXL = 1.
- BadVAddr = exc_badv if exc_badv_we.
- If Status.EXL is already 1: EPC and Cause.BD are NOT updated; ExcCode still is.

eret:
- Status.EXL = 0.

Collision priority, highest first: exception > eret > mtc0.
- exc_valid overrides any mtc0 to EPC, Cause or Status fields it touches. Other mtc0 fields in that cycle still apply.
- eret overrides mtc0 to Status.EXL.

rdata:
- Selects the current register value by raddr.

Optional Feature:
CP0_FORWARD_EN:
- Defined: if we && raddr==waddr and the register is writable, rdata returns the post-write value (wdata merged under that register's write mask) in the same cycle. This avoids a mfc0-after-mtc0 stall.
- Undefined: rdata always returns the registered value, and the write becomes visible on the next cycle.

Test Plan:
- Reset: assert rst=0 mid-run with Count=0x55 -> all outputs at reset values immediately (no clk edge). Release -> Count is 0, and after 2*COUNT_DIV cycles Count=2.
- Timer: mtc0 Compare=5, Count=0, COUNT_DIV=2 -> timer_int=1 one cycle after Count reaches 5 and Cause[30]=1. mtc0 Compare=5 again -> timer_int=0 the next cycle. Count=FFFFFFFF -> wraps to 0.
- Interrupt mask: Status=0x0000FF01, hw_int[0]=1 -> int_pending=1 one cycle later. Status.IM2=0 -> int_pending=0. exc_valid (ExcCode=0) -> EXL=1, so int_pending=0.
- Delay-slot exception: exc_valid, exc_code=4, exc_bd=1, exc_pc=0xBFC00104, exc_badv_we, exc_badv=0x1003 -> EPC=0xBFC00100, Cause[31]=1, Cause[6:2]=4, BadVAddr=0x1003, Status[1]=1.
- Nested and collision:
  - Second exception while EXL=1 with exc_pc=0x200 -> EPC unchanged, ExcCode updated.
  - exc_valid + mtc0 EPC=0x1234 in the same cycle -> EPC from the exception.
  - eret + mtc0 Status=0x3 -> Status=0x1.
- Forwarding: mtc0 Status=0xFF01 with raddr=12 in the same cycle -> rdata=0xFF01 when CP0_FORWARD_EN is defined, otherwise the old value (0x10000000).
